// File: rtl/rans_stream_decoder.sv
// Frame-based rANS decoder. Loads a coder state from the input word stream,
// then decodes frame_len symbols using a sequential restoring divider and a
// single-cycle parallel symbol lookup, renormalising from the stream when the
// state drops below the table total M.
//
// Handshakes: a word moves on the input side in any cycle where
// in_vld && in_rdy at the rising edge (with ena high); a symbol moves on the
// output side in any cycle where out_vld && out_rdy. A valid holds its data
// stable until the transfer. Back-to-back transfers are allowed. in_rdy is
// never raised while out_vld is high.
`timescale 1ns/1ps
module rans_stream_decoder #(
  parameter int SYM_WIDTH   = 4,
  parameter int CNT_WIDTH   = 8,
  parameter int SYM_COUNT   = 16,
  parameter int STATE_WIDTH = 32,
  parameter int LEN_WIDTH   = 16
) (
  input  logic                                   clk,
  input  logic                                   rst_n,
  input  logic                                   ena,
  input  logic                                   start,
  input  logic [LEN_WIDTH-1:0]                   frame_len,
  input  logic [CNT_WIDTH*SYM_COUNT-1:0]         counts_unpacked,
  input  logic [(CNT_WIDTH+SYM_WIDTH)*SYM_COUNT-1:0] cumulative_unpacked,
  input  logic [SYM_WIDTH-1:0]                   in,
  input  logic                                   in_vld,
  output logic                                   in_rdy,
  output logic [SYM_WIDTH-1:0]                   out,
  output logic                                   out_vld,
  input  logic                                   out_rdy,
  output logic                                   out_last,
  output logic                                   busy,
  output logic                                   done,
  output logic                                   err,
  output logic [STATE_WIDTH-1:0]                 final_state,
  output logic [2:0]                             dbg_state
);

  localparam int CUM_WIDTH     = CNT_WIDTH + SYM_WIDTH;
  localparam int NUM_WORDS     = STATE_WIDTH / SYM_WIDTH;
  localparam int PTR_WIDTH     = $clog2(NUM_WORDS);
  localparam int DIV_CNT_WIDTH = $clog2(STATE_WIDTH);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LOAD   = 3'd1,
    S_DIV    = 3'd2,
    S_EMIT   = 3'd3,
    S_UPDATE = 3'd4,
    S_RENORM = 3'd5,
    S_DONE   = 3'd6
  } state_t;

  state_t                   state;
  logic [STATE_WIDTH-1:0]   x;
  logic [STATE_WIDTH-1:0]   q;
  logic [CUM_WIDTH-1:0]     r;
  logic [PTR_WIDTH-1:0]     ptr;
  logic [LEN_WIDTH-1:0]     remaining;
  logic [DIV_CNT_WIDTH-1:0] div_cnt;

  logic [CUM_WIDTH-1:0]     cum_a [SYM_COUNT];
  logic [CNT_WIDTH-1:0]     cnt_a [SYM_COUNT];
  logic [CUM_WIDTH-1:0]     m_total;
  logic [SYM_WIDTH-1:0]     sym_c;
  logic [CNT_WIDTH-1:0]     cnt_sym;
  logic [CUM_WIDTH-1:0]     lo_sym;
  logic                     div_bit;
  logic [CUM_WIDTH:0]       rem_shift;
  logic                     rem_ge;
  logic [CUM_WIDTH-1:0]     rem_next;
  logic [STATE_WIDTH-1:0]   x_upd;
  logic [STATE_WIDTH-1:0]   x_shift;
  logic [LEN_WIDTH-1:0]     rem_dec;

  assign dbg_state = state;

  // Slice the flat table buses into per-symbol entries.
  always_comb begin
    for (int j = 0; j < SYM_COUNT; j++) begin
      cum_a[j] = cumulative_unpacked[j*CUM_WIDTH +: CUM_WIDTH];
      cnt_a[j] = counts_unpacked[j*CNT_WIDTH +: CNT_WIDTH];
    end
    m_total = cumulative_unpacked[(SYM_COUNT-1)*CUM_WIDTH +: CUM_WIDTH];
  end

  // Parallel lookup: smallest symbol whose inclusive cumulative exceeds r.
  always_comb begin
    sym_c = '0;
    for (int j = SYM_COUNT-1; j >= 0; j--) begin
      if (cum_a[j] > r) sym_c = SYM_WIDTH'(j);
    end
    cnt_sym = cnt_a[sym_c];
    lo_sym  = (sym_c == '0) ? '0 : cum_a[sym_c - SYM_WIDTH'(1)];
  end

  // One restoring-division step, the state update and the renorm shift.
  always_comb begin
    div_bit   = x[DIV_CNT_WIDTH'(STATE_WIDTH-1) - div_cnt];
    rem_shift = {r, div_bit};
    rem_ge    = (rem_shift >= {1'b0, m_total});
    rem_next  = rem_ge ? CUM_WIDTH'(rem_shift - {1'b0, m_total}) : rem_shift[CUM_WIDTH-1:0];
    x_upd     = q * STATE_WIDTH'(cnt_sym) + STATE_WIDTH'(r) - STATE_WIDTH'(lo_sym);
    x_shift   = {x[STATE_WIDTH-SYM_WIDTH-1:0], in};
    rem_dec   = remaining - LEN_WIDTH'(1);
  end

  // Control FSM with registered outputs; ena low freezes everything.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= S_IDLE;
      x           <= '0;
      q           <= '0;
      r           <= '0;
      ptr         <= '0;
      remaining   <= '0;
      div_cnt     <= '0;
      in_rdy      <= 1'b0;
      out         <= '0;
      out_vld     <= 1'b0;
      out_last    <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      err         <= 1'b0;
      final_state <= '0;
    end else if (ena) begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            if (m_total == '0) begin
              err  <= 1'b1;
              done <= 1'b1;
            end else if (frame_len == '0) begin
              err         <= 1'b0;
              done        <= 1'b1;
              final_state <= '0;
            end else begin
              err       <= 1'b0;
              remaining <= frame_len;
              x         <= '0;
              ptr       <= '0;
              in_rdy    <= 1'b1;
              busy      <= 1'b1;
              state     <= S_LOAD;
            end
          end
        end
        S_LOAD: begin
          if (in_vld && in_rdy) begin
            x[ptr*SYM_WIDTH +: SYM_WIDTH] <= in;
            ptr <= ptr + PTR_WIDTH'(1);
            if (ptr == PTR_WIDTH'(NUM_WORDS-1)) begin
              in_rdy  <= 1'b0;
              div_cnt <= '0;
              q       <= '0;
              r       <= '0;
              state   <= S_DIV;
            end
          end
        end
        S_DIV: begin
          r       <= rem_next;
          q       <= {q[STATE_WIDTH-2:0], rem_ge};
          div_cnt <= div_cnt + DIV_CNT_WIDTH'(1);
          if (div_cnt == DIV_CNT_WIDTH'(STATE_WIDTH-1)) state <= S_EMIT;
        end
        S_EMIT: begin
          // First cycle presents the symbol; it then holds until accepted.
          if (!out_vld) begin
            out      <= sym_c;
            out_vld  <= 1'b1;
            out_last <= (remaining == LEN_WIDTH'(1));
          end else if (out_rdy) begin
            out_vld  <= 1'b0;
            out_last <= 1'b0;
            state    <= S_UPDATE;
          end
        end
        S_UPDATE: begin
          remaining <= rem_dec;
          x         <= x_upd;
          if (rem_dec == '0) begin
            final_state <= x_upd;
            done        <= 1'b1;
            state       <= S_DONE;
          end else if (x_upd < STATE_WIDTH'(m_total)) begin
            in_rdy <= 1'b1;
            state  <= S_RENORM;
          end else begin
            div_cnt <= '0;
            q       <= '0;
            r       <= '0;
            state   <= S_DIV;
          end
        end
        S_RENORM: begin
          if (in_vld && in_rdy) begin
            x <= x_shift;
            if (x_shift >= STATE_WIDTH'(m_total)) begin
              in_rdy  <= 1'b0;
              div_cnt <= '0;
              q       <= '0;
              r       <= '0;
              state   <= S_DIV;
            end
          end
        end
        S_DONE: begin
          busy  <= 1'b0;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_rans_stream_decoder.sv
// Bench for rans_stream_decoder: directed frames from known tables, stalls,
// enable freeze, error/empty starts, mid-frame reset and randomised tables
// checked against a behavioural rANS model.
`timescale 1ns/1ps
module tb_rans_stream_decoder;
  localparam int SW = 4;
  localparam int CW = 8;
  localparam int SC = 16;
  localparam int XW = 32;
  localparam int LW = 16;
  localparam int MW = CW + SW;
  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_DIV  = 3'd2;

  logic              clk, rst_n, ena, start;
  logic [LW-1:0]     frame_len;
  logic [CW*SC-1:0]  counts_unpacked;
  logic [MW*SC-1:0]  cumulative_unpacked;
  logic [SW-1:0]     in;
  logic              in_vld, in_rdy;
  logic [SW-1:0]     out;
  logic              out_vld, out_rdy, out_last, busy, done, err;
  logic [XW-1:0]     final_state;
  logic [2:0]        dbg_state;

  logic [SW:0]       exp_q[$];
  logic [SW-1:0]     in_q[$];
  int                checks = 0;
  int                failures = 0;
  int                in_acc, done_cnt, last_cnt;
  int                proto_err = 0;
  bit                busy_seen, rdy_seen, in_fire, rand_rdy;
  logic [XW-1:0]     fs_cap;
  int                tb_cnt[SC];

  rans_stream_decoder dut (
    .clk(clk), .rst_n(rst_n), .ena(ena), .start(start), .frame_len(frame_len),
    .counts_unpacked(counts_unpacked), .cumulative_unpacked(cumulative_unpacked),
    .in(in), .in_vld(in_vld), .in_rdy(in_rdy), .out(out), .out_vld(out_vld),
    .out_rdy(out_rdy), .out_last(out_last), .busy(busy), .done(done), .err(err),
    .final_state(final_state), .dbg_state(dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // input feeder: offers the head of in_q, pops on the edge that took it
  initial begin
    in_vld = 1'b0; in = '0; in_fire = 1'b0;
    forever begin
      @(negedge clk);
      if (in_fire && in_q.size() > 0) begin
        void'(in_q.pop_front());
        in_acc++;
      end
      in_vld  = (in_q.size() > 0);
      in      = in_vld ? in_q[0] : '0;
      in_fire = in_vld && in_rdy && ena && rst_n;
      if (in_rdy && out_vld) proto_err++;
    end
  end

  // output scoreboard and event monitor
  initial begin
    logic [SW:0] e;
    forever begin
      @(negedge clk);
      if (rst_n && ena && out_vld && out_rdy) begin
        checks++;
        if (exp_q.size() == 0) begin
          failures++;
          $display("FAIL out_unexpected got sym=%h last=%b with nothing expected", out, out_last);
        end else begin
          e = exp_q.pop_front();
          if ({out_last, out} !== e) begin
            failures++;
            $display("FAIL out_symbol got last=%b sym=%h exp last=%b sym=%h", out_last, out, e[SW], e[SW-1:0]);
          end
        end
        if (out_last) last_cnt++;
      end
      if (rst_n && done) begin
        done_cnt++;
        fs_cap = final_state;
      end
      if (busy) busy_seen = 1'b1;
      if (in_rdy) rdy_seen = 1'b1;
    end
  end

  // random backpressure on out_rdy when enabled
  initial begin
    forever begin
      @(posedge clk); #1;
      if (rand_rdy) out_rdy = ($urandom_range(0, 3) != 0);
    end
  end

  // driver tasks
  task automatic set_table();
    int acc;
    acc = 0;
    for (int j = 0; j < SC; j++) begin
      counts_unpacked[j*CW +: CW] = CW'(tb_cnt[j]);
      acc += tb_cnt[j];
      cumulative_unpacked[j*MW +: MW] = MW'(acc);
    end
  endtask

  task automatic set_uniform();
    for (int j = 0; j < SC; j++) tb_cnt[j] = 1;
    set_table();
  endtask

  task automatic do_reset();
    rst_n = 1'b0; start = 1'b0; ena = 1'b1; out_rdy = 1'b1; rand_rdy = 1'b0; frame_len = '0;
    in_q.delete(); exp_q.delete();
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    in_acc = 0; done_cnt = 0; last_cnt = 0; busy_seen = 1'b0; rdy_seen = 1'b0;
  endtask

  task automatic start_frame(input int flen);
    @(posedge clk); #1;
    frame_len = LW'(flen); start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_done(input int budget, output bit ok);
    int base;
    base = done_cnt; ok = 1'b0;
    for (int i = 0; i < budget && !ok; i++) begin
      @(negedge clk); #1;
      if (done_cnt != base) ok = 1'b1;
    end
  endtask

  task automatic wait_loaded(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 200 && !ok; i++) begin
      @(negedge clk); #1;
      if (in_acc >= 8) ok = 1'b1;
    end
  endtask

  task automatic push_x(input logic [XW-1:0] x);
    for (int i = 0; i < XW/SW; i++) in_q.push_back(x[i*SW +: SW]);
  endtask

  task automatic push_scn1();
    push_x(32'h89AB_CDEF);
    exp_q.push_back({1'b0, 4'hF}); exp_q.push_back({1'b0, 4'hE});
    exp_q.push_back({1'b0, 4'hD}); exp_q.push_back({1'b1, 4'hC});
  endtask

  // tests
  task automatic test_reset();
    do_reset();
    @(negedge clk);
    checks++;
    if ({in_rdy, out, out_vld, out_last, busy, done, err, final_state, dbg_state} !== '0) begin
      failures++;
      $display("FAIL reset_outputs got rdy=%b out=%h vld=%b last=%b busy=%b done=%b err=%b fs=%h st=%0d exp all zero",
               in_rdy, out, out_vld, out_last, busy, done, err, final_state, dbg_state);
    end
  endtask

  task automatic test_uniform_no_renorm();
    bit ok;
    do_reset(); set_uniform(); push_scn1();
    start_frame(4);
    wait_done(3000, ok);
    checks++; if (!ok) begin failures++; $display("FAIL u1_done got timeout exp done pulse"); end
    checks++; if (exp_q.size() != 0) begin failures++; $display("FAIL u1_symbols got %0d left exp 0", exp_q.size()); end
    checks++; if (fs_cap !== 32'h89AB) begin failures++; $display("FAIL u1_final got %h exp 000089ab", fs_cap); end
    checks++; if (in_acc != 8) begin failures++; $display("FAIL u1_words got %0d exp 8", in_acc); end
    checks++; if (last_cnt != 1) begin failures++; $display("FAIL u1_last got %0d exp 1", last_cnt); end
    @(negedge clk);
    checks++; if ({busy, err, dbg_state} !== {1'b0, 1'b0, ST_IDLE}) begin
      failures++; $display("FAIL u1_idle got busy=%b err=%b st=%0d exp 0 0 0", busy, err, dbg_state);
    end
  endtask

  task automatic test_uniform_renorm();
    bit ok;
    do_reset(); set_uniform();
    push_x(32'h12); in_q.push_back(4'h7); in_q.push_back(4'h0);
    exp_q.push_back({1'b0, 4'h2}); exp_q.push_back({1'b0, 4'h7}); exp_q.push_back({1'b1, 4'h0});
    start_frame(3);
    wait_done(3000, ok);
    checks++; if (!ok) begin failures++; $display("FAIL u2_done got timeout exp done pulse"); end
    checks++; if (exp_q.size() != 0) begin failures++; $display("FAIL u2_symbols got %0d left exp 0", exp_q.size()); end
    checks++; if (fs_cap !== 32'h1) begin failures++; $display("FAIL u2_final got %h exp 00000001", fs_cap); end
    checks++; if (in_acc != 10) begin failures++; $display("FAIL u2_words got %0d exp 10", in_acc); end
  endtask

  task automatic test_skewed();
    bit ok;
    do_reset();
    for (int j = 0; j < SC; j++) tb_cnt[j] = 0;
    tb_cnt[0] = 12; tb_cnt[1] = 4;
    set_table();
    push_x(32'd37);
    exp_q.push_back({1'b0, 4'h0}); exp_q.push_back({1'b1, 4'h1});
    start_frame(2);
    wait_done(3000, ok);
    checks++; if (!ok) begin failures++; $display("FAIL sk_done got timeout exp done pulse"); end
    checks++; if (exp_q.size() != 0) begin failures++; $display("FAIL sk_symbols got %0d left exp 0", exp_q.size()); end
    checks++; if (fs_cap !== 32'd5) begin failures++; $display("FAIL sk_final got %h exp 00000005", fs_cap); end
    checks++; if (in_acc != 8) begin failures++; $display("FAIL sk_words got %0d exp 8", in_acc); end
  endtask

  task automatic test_backpressure();
    bit ok;
    logic [SW-1:0] o;
    logic [2:0] st;
    do_reset(); set_uniform(); push_scn1();
    out_rdy = 1'b0;
    start_frame(4);
    ok = 1'b0;
    for (int i = 0; i < 300 && !ok; i++) begin
      @(negedge clk); #1;
      if (out_vld) ok = 1'b1;
    end
    checks++; if (!ok) begin failures++; $display("FAIL bp_first_valid got timeout exp out_vld"); end
    o = out; st = dbg_state;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checks++;
      if ({out_vld, out, dbg_state, in_rdy} !== {1'b1, o, st, 1'b0}) begin
        failures++;
        $display("FAIL bp_stall got vld=%b out=%h st=%0d rdy=%b exp 1 %h %0d 0", out_vld, out, dbg_state, in_rdy, o, st);
      end
    end
    @(posedge clk); #1 out_rdy = 1'b1;
    wait_done(3000, ok);
    checks++; if (!ok) begin failures++; $display("FAIL bp_done got timeout exp done pulse"); end
    checks++; if (exp_q.size() != 0) begin failures++; $display("FAIL bp_symbols got %0d left exp 0", exp_q.size()); end
    checks++; if (fs_cap !== 32'h89AB) begin failures++; $display("FAIL bp_final got %h exp 000089ab", fs_cap); end
  endtask

  task automatic test_error();
    bit ok;
    do_reset();
    for (int j = 0; j < SC; j++) tb_cnt[j] = 0;
    set_table();
    start_frame(5);
    wait_done(5, ok);
    checks++; if (!ok) begin failures++; $display("FAIL err_done got timeout exp done pulse"); end
    checks++; if (err !== 1'b1) begin failures++; $display("FAIL err_flag got %b exp 1", err); end
    repeat (4) @(negedge clk);
    checks++; if ({rdy_seen, busy_seen} !== 2'b00 || done_cnt != 1) begin
      failures++; $display("FAIL err_quiet got rdy_seen=%b busy_seen=%b dones=%0d exp 0 0 1", rdy_seen, busy_seen, done_cnt);
    end
    checks++; if (err !== 1'b1) begin failures++; $display("FAIL err_sticky got %b exp 1", err); end
    set_uniform(); push_scn1();
    start_frame(4);
    @(negedge clk);
    checks++; if (err !== 1'b0) begin failures++; $display("FAIL err_clear got %b exp 0", err); end
    wait_done(3000, ok);
    checks++; if (!ok || fs_cap !== 32'h89AB) begin
      failures++; $display("FAIL err_recover got ok=%b fs=%h exp 1 000089ab", ok, fs_cap);
    end
  endtask

  task automatic test_zero_len();
    bit ok;
    busy_seen = 1'b0;
    checks++; if (final_state !== 32'h89AB) begin failures++; $display("FAIL zl_before got %h exp 000089ab", final_state); end
    start_frame(0);
    wait_done(5, ok);
    checks++; if (!ok) begin failures++; $display("FAIL zl_done got timeout exp done pulse"); end
    checks++; if (fs_cap !== '0 || busy_seen) begin
      failures++; $display("FAIL zl_final got fs=%h busy_seen=%b exp 0 0", fs_cap, busy_seen);
    end
  endtask

  task automatic test_reset_mid_div();
    bit ok;
    int dc;
    do_reset(); set_uniform(); push_scn1();
    start_frame(4);
    wait_loaded(ok);
    repeat (4) @(negedge clk);
    checks++; if (!ok || dbg_state !== ST_DIV) begin
      failures++; $display("FAIL rst_in_div got loaded=%b st=%0d exp 1 %0d", ok, dbg_state, ST_DIV);
    end
    @(posedge clk); #1 rst_n = 1'b0;
    #1;
    checks++;
    if ({in_rdy, out, out_vld, out_last, busy, done, err, final_state, dbg_state} !== '0) begin
      failures++; $display("FAIL rst_mid_outputs got rdy=%b out=%h vld=%b busy=%b fs=%h st=%0d exp all zero",
                           in_rdy, out, out_vld, busy, final_state, dbg_state);
    end
    in_q.delete(); exp_q.delete();
    @(posedge clk); #1 rst_n = 1'b1;
    dc = done_cnt;
    repeat (20) @(negedge clk);
    checks++; if (busy !== 1'b0 || done_cnt != dc || out_vld !== 1'b0) begin
      failures++; $display("FAIL rst_mid_quiet got busy=%b dones=%0d vld=%b exp 0 %0d 0", busy, done_cnt, out_vld, dc);
    end
    in_acc = 0;
    push_scn1();
    start_frame(4);
    wait_done(3000, ok);
    checks++; if (!ok || exp_q.size() != 0 || fs_cap !== 32'h89AB) begin
      failures++; $display("FAIL rst_mid_rerun got ok=%b left=%0d fs=%h exp 1 0 000089ab", ok, exp_q.size(), fs_cap);
    end
  endtask

  task automatic test_ena_freeze();
    bit ok;
    logic [9:0] snap;
    do_reset(); set_uniform();
    push_x(32'h12); in_q.push_back(4'h7); in_q.push_back(4'h0);
    exp_q.push_back({1'b0, 4'h2}); exp_q.push_back({1'b0, 4'h7}); exp_q.push_back({1'b1, 4'h0});
    start_frame(3);
    wait_loaded(ok);
    @(posedge clk); #1 ena = 1'b0;
    @(negedge clk);
    snap = {dbg_state, in_rdy, out, out_vld, busy};
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      checks++;
      if ({dbg_state, in_rdy, out, out_vld, busy} !== snap) begin
        failures++; $display("FAIL ena_hold got %h exp %h", {dbg_state, in_rdy, out, out_vld, busy}, snap);
      end
    end
    @(posedge clk); #1 ena = 1'b1;
    wait_done(3000, ok);
    checks++; if (!ok || exp_q.size() != 0 || fs_cap !== 32'h1 || in_acc != 10) begin
      failures++; $display("FAIL ena_resume got ok=%b left=%0d fs=%h words=%0d exp 1 0 00000001 10", ok, exp_q.size(), fs_cap, in_acc);
    end
  endtask

  task automatic test_random_tables();
    bit ok;
    int cum[SC];
    int m, flen, sym;
    logic [XW-1:0] x, q, r, lo;
    logic [SW-1:0] w;
    for (int f = 0; f < 4; f++) begin
      do_reset();
      for (int j = 0; j < SC; j++) tb_cnt[j] = $urandom_range(0, 5);
      tb_cnt[$urandom_range(0, SC-1)] += 1;
      set_table();
      m = 0;
      for (int j = 0; j < SC; j++) begin m += tb_cnt[j]; cum[j] = m; end
      x = {16'h0, 16'($urandom)};
      push_x(x);
      flen = $urandom_range(4, 10);
      for (int i = 0; i < flen; i++) begin
        q = x / m; r = x % m;
        sym = 0;
        while (cum[sym] <= r) sym++;
        lo = (sym == 0) ? 0 : cum[sym-1];
        exp_q.push_back({(i == flen-1), SW'(sym)});
        x = q * tb_cnt[sym] + r - lo;
        if (i != flen-1) begin
          while (x < m) begin
            w = SW'($urandom_range(0, 15));
            in_q.push_back(w);
            x = {x[XW-SW-1:0], w};
          end
        end
      end
      rand_rdy = 1'b1;
      start_frame(flen);
      wait_done(6000, ok);
      rand_rdy = 1'b0; out_rdy = 1'b1;
      checks++;
      if (!ok || exp_q.size() != 0 || in_q.size() != 0 || fs_cap !== x) begin
        failures++; $display("FAIL rand_frame%0d got ok=%b left=%0d words_left=%0d fs=%h exp 1 0 0 %h",
                             f, ok, exp_q.size(), in_q.size(), fs_cap, x);
      end
    end
  endtask

  initial begin
    test_reset();
    test_uniform_no_renorm();
    test_uniform_renorm();
    test_skewed();
    test_backpressure();
    test_error();
    test_zero_len();
    test_reset_mid_div();
    test_ena_freeze();
    test_random_tables();
    checks++;
    if (proto_err != 0) begin
      failures++; $display("FAIL in_rdy_with_out_vld got %0d cycles exp 0", proto_err);
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
